// File: rtl/ski_step_sequencer.sv
// Sequencer around the combinational SKI reduction step.
// Owns the 346-bit machine state, seeds it from a root expression and fetches
// heap nodes whenever the current expression is a pointer node. It then clocks
// one reduction step per evaluation cycle until the step function halts, the
// step budget runs out, or software aborts the run.
module ski_step_sequencer #(
  parameter int MAX_STEPS = 1048576,
  parameter int ADDR_W    = 30,
  parameter int CNT_W     = 32
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [62:0]       root_i,
  input  logic [ADDR_W-1:0] heap_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [62:0]       result_o,
  output logic [CNT_W-1:0]  steps_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [1:0]        mem_rkind_i,
  input  logic [125:0]      mem_rdata_i,
  output logic [345:0]      step_state_o,
  output logic [127:0]      step_mem_o,
  input  logic [345:0]      step_next_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_REQ,
    S_WAIT,
    S_DONE
  } seqState_t;

  localparam logic [CNT_W-1:0] Budget = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  seqState_t         fsm_q;
  logic [345:0]      state_q;
  logic [127:0]      heldWord_q;
  logic              heldValid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [62:0]       result_q;
  logic [CNT_W-1:0]  steps_q;
  logic [CNT_W-1:0]  steps_d;
  logic              memReq_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic              isHalted;
  logic              isPointer;
  logic              budgetHit;

  // Decode the machine state: halt tag, pointer node, and an exhausted budget.
  always_comb begin
    isHalted  = (state_q[345:344] == 2'b10);
    isPointer = (state_q[62:60] == 3'b011);
    budgetHit = (MAX_STEPS != 0) && (steps_q == Budget);
  end

  // The step counter sticks at all-ones rather than wrapping on very long runs.
  always_comb begin
    steps_d = (steps_q == '1) ? steps_q : steps_q + CntOne;
  end

  // Main sequencer: reset and abort take priority over the per-state behaviour.
  // done_q defaults low every cycle, so a halt produces a single-cycle pulse.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      heldWord_q  <= '0;
      heldValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      steps_q     <= '0;
      memReq_q    <= 1'b0;
      memAddr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && (fsm_q != S_IDLE)) begin
        fsm_q       <= S_IDLE;
        busy_q      <= 1'b0;
        memReq_q    <= 1'b0;
        heldValid_q <= 1'b0;
        heldWord_q  <= '0;
      end else begin
        case (fsm_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q     <= {2'b00, 251'b0, heap_base_i, root_i};
              steps_q     <= '0;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              heldValid_q <= 1'b0;
              heldWord_q  <= '0;
              fsm_q       <= S_EVAL;
            end
          end
          S_EVAL: begin
            if (isHalted) begin
              result_q <= state_q[62:0];
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              fsm_q    <= S_DONE;
            end else if (budgetHit) begin
              result_q <= state_q[62:0];
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              fsm_q    <= S_IDLE;
            end else if (isPointer && !heldValid_q) begin
              memReq_q  <= 1'b1;
              memAddr_q <= state_q[59:30];
              fsm_q     <= S_REQ;
            end else begin
              state_q     <= step_next_i;
              steps_q     <= steps_d;
              heldValid_q <= 1'b0;
              heldWord_q  <= '0;
            end
          end
          S_REQ: begin
            if (mem_gnt_i) begin
              memReq_q <= 1'b0;
              fsm_q    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_rvalid_i && (mem_rkind_i != 2'b00)) begin
              heldWord_q  <= {mem_rkind_i, mem_rdata_i};
              heldValid_q <= 1'b1;
              fsm_q       <= S_EVAL;
            end
          end
          S_DONE: begin
            fsm_q <= S_IDLE;
          end
          default: begin
            fsm_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign result_o     = result_q;
  assign steps_o      = steps_q;
  assign mem_req_o    = memReq_q & ~abort;
  assign mem_addr_o   = memAddr_q;
  assign step_state_o = state_q;
  assign step_mem_o   = heldValid_q ? heldWord_q : 128'b0;

endmodule

// File: tb/tb_ski_step_sequencer.sv
// Directed bench for ski_step_sequencer. Two instances share all stimulus:
// dutA keeps the default budget, dutB runs with a budget of 5 steps. Each is
// closed around a tiny reference step function.
module tb_ski_step_sequencer;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [62:0]   rootI;
  logic [29:0]   heapBase;
  logic          memGnt;
  logic          memRvalid;
  logic [1:0]    memRkind;
  logic [125:0]  memRdata;

  logic          busyA, doneA, errA, memReqA;
  logic [62:0]   resultA;
  logic [31:0]   stepsA;
  logic [29:0]   memAddrA;
  logic [345:0]  stepStateA, stepNextA;
  logic [127:0]  stepMemA;

  logic          busyB, doneB, errB, memReqB;
  logic [62:0]   resultB;
  logic [31:0]   stepsB;
  logic [29:0]   memAddrB;
  logic [345:0]  stepStateB, stepNextB;
  logic [127:0]  stepMemB;

  int vectors;
  int miscompares;

  logic [62:0] leafRoot;
  logic [62:0] pointerRoot;
  logic [62:0] spinRoot;
  logic [62:0] fetchedLeaf;

  // Reference step: leaf nodes halt, a pointer with a fetched word becomes the
  // fetched node, anything else just marks the machine running.
  function automatic logic [345:0] stepModel(input logic [345:0] s, input logic [127:0] m);
    if (s[62:60] == 3'b100) return {2'b10, s[343:0]};
    if ((s[62:60] == 3'b011) && (m[127:126] != 2'b00)) return {2'b01, s[343:63], m[62:0]};
    return {2'b01, s[343:0]};
  endfunction

  assign stepNextA = stepModel(stepStateA, stepMemA);
  assign stepNextB = stepModel(stepStateB, stepMemB);

  ski_step_sequencer dutA (
    .system1000(clk), .system1000_rst(rst), .start(start), .abort(abort),
    .root_i(rootI), .heap_base_i(heapBase),
    .busy_o(busyA), .done_o(doneA), .err_o(errA), .result_o(resultA), .steps_o(stepsA),
    .mem_req_o(memReqA), .mem_addr_o(memAddrA), .mem_gnt_i(memGnt),
    .mem_rvalid_i(memRvalid), .mem_rkind_i(memRkind), .mem_rdata_i(memRdata),
    .step_state_o(stepStateA), .step_mem_o(stepMemA), .step_next_i(stepNextA)
  );

  ski_step_sequencer #(.MAX_STEPS(5)) dutB (
    .system1000(clk), .system1000_rst(rst), .start(start), .abort(abort),
    .root_i(rootI), .heap_base_i(heapBase),
    .busy_o(busyB), .done_o(doneB), .err_o(errB), .result_o(resultB), .steps_o(stepsB),
    .mem_req_o(memReqB), .mem_addr_o(memAddrB), .mem_gnt_i(memGnt),
    .mem_rvalid_i(memRvalid), .mem_rkind_i(memRkind), .mem_rdata_i(memRdata),
    .step_state_o(stepStateB), .step_mem_o(stepMemB), .step_next_i(stepNextB)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [345:0] got, input logic [345:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks and settle just after the active edge.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present start/abort for exactly one clock edge.
  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    waitCycles(1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // All dutA outputs at their reset values.
  task automatic checkReset(input string pfx);
    checkOutput({pfx, " busy"}, busyA, 0);
    checkOutput({pfx, " done"}, doneA, 0);
    checkOutput({pfx, " err"}, errA, 0);
    checkOutput({pfx, " result"}, resultA, 0);
    checkOutput({pfx, " steps"}, stepsA, 0);
    checkOutput({pfx, " memReq"}, memReqA, 0);
    checkOutput({pfx, " memAddr"}, memAddrA, 0);
    checkOutput({pfx, " state"}, stepStateA, 0);
    checkOutput({pfx, " stepMem"}, stepMemA, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    leafRoot    = {3'b100, 60'h123456789ABCDEF};
    pointerRoot = {3'b011, 30'd256, 30'd7};
    spinRoot    = {3'b000, 60'h5A5};
    fetchedLeaf = {3'b100, 60'hABC};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rootI = '0; heapBase = 30'h1234;
    memGnt = 1'b0; memRvalid = 1'b0; memRkind = 2'b00;
    memRdata = {63'h0, fetchedLeaf};

    waitCycles(2);
    checkReset("reset");
    rst = 1'b0;
    waitCycles(1);

    // Leaf root halts after one step.
    rootI = leafRoot;
    applyStimulus(1'b1, 1'b0);
    checkOutput("leaf busy", busyA, 1);
    checkOutput("leaf seed", stepStateA, {2'b00, 251'b0, heapBase, leafRoot});
    checkOutput("leaf steps0", stepsA, 0);
    waitCycles(1);
    checkOutput("leaf noDoneYet", doneA, 0);
    checkOutput("leaf steps1", stepsA, 1);
    checkOutput("leaf haltTag", stepStateA[345:344], 2'b10);
    waitCycles(1);
    checkOutput("leaf done", doneA, 1);
    checkOutput("leaf result", resultA, leafRoot);
    checkOutput("leaf idle", busyA, 0);
    checkOutput("leaf noReq", memReqA, 0);
    waitCycles(1);
    checkOutput("leaf donePulse", doneA, 0);

    // Pointer root: fetch with delayed grant, kind-00 beat ignored, pair word used.
    rootI = pointerRoot;
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    checkOutput("ptr req", memReqA, 1);
    checkOutput("ptr addr", memAddrA, 30'd256);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("ptr reqHeld", memReqA, 1);
      checkOutput("ptr addrHeld", memAddrA, 30'd256);
    end
    memGnt = 1'b1;
    #1;
    checkOutput("ptr reqAtGnt", memReqA, 1);
    waitCycles(1);
    memGnt = 1'b0;
    checkOutput("ptr reqDropped", memReqA, 0);
    memRvalid = 1'b1; memRkind = 2'b00;
    waitCycles(1);
    checkOutput("ptr kind00", stepMemA, 0);
    memRkind = 2'b10;
    waitCycles(1);
    memRvalid = 1'b0; memRkind = 2'b00;
    checkOutput("ptr memTag", stepMemA[127:126], 2'b10);
    checkOutput("ptr memWord", stepMemA, {2'b10, 63'h0, fetchedLeaf});
    waitCycles(1);
    checkOutput("ptr memOnce", stepMemA, 0);
    checkOutput("ptr steps1", stepsA, 1);
    checkOutput("ptr newCur", stepStateA[62:0], fetchedLeaf);
    waitCycles(1);
    checkOutput("ptr steps2", stepsA, 2);
    waitCycles(1);
    checkOutput("ptr done", doneA, 1);
    checkOutput("ptr result", resultA, fetchedLeaf);
    waitCycles(1);

    // Budget of 5 on dutB with a never-halting expression.
    rootI = spinRoot;
    applyStimulus(1'b1, 1'b0);
    waitCycles(5);
    checkOutput("budget steps5", stepsB, 5);
    checkOutput("budget stillBusy", busyB, 1);
    checkOutput("budget noErrYet", errB, 0);
    waitCycles(1);
    checkOutput("budget err", errB, 1);
    checkOutput("budget busy", busyB, 0);
    checkOutput("budget noDone", doneB, 0);
    checkOutput("budget noReq", memReqB, 0);
    checkOutput("budget result", resultB, spinRoot);
    checkOutput("budget stepsHeld", stepsB, 5);
    checkOutput("budget unlimitedA", stepsA, 6);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortA busy", busyA, 0);
    checkOutput("abortA err", errA, 0);
    checkOutput("abortA done", doneA, 0);
    checkOutput("abortA steps", stepsA, 6);
    checkOutput("budget errSticky", errB, 1);

    // Abort while waiting for read data; the late response is ignored.
    rootI = pointerRoot;
    applyStimulus(1'b1, 1'b0);
    checkOutput("waitAbort errCleared", errB, 0);
    waitCycles(1);
    memGnt = 1'b1;
    waitCycles(1);
    memGnt = 1'b0;
    checkOutput("waitAbort inWait", memReqA, 0);
    checkOutput("waitAbort busy", busyA, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("waitAbort idle", busyA, 0);
    memRvalid = 1'b1; memRkind = 2'b10;
    waitCycles(1);
    memRvalid = 1'b0; memRkind = 2'b00;
    checkOutput("lateData stepMem", stepMemA, 0);
    checkOutput("lateData busy", busyA, 0);
    checkOutput("lateData done", doneA, 0);
    rootI = leafRoot;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rerun steps0", stepsA, 0);
    checkOutput("rerun busy", busyA, 1);
    checkOutput("rerun stepMem", stepMemA, 0);
    waitCycles(1);
    checkOutput("rerun steps1", stepsA, 1);
    waitCycles(1);
    checkOutput("rerun done", doneA, 1);
    checkOutput("rerun result", resultA, leafRoot);
    waitCycles(1);

    // Abort in REQ removes the request in the same cycle.
    rootI = pointerRoot;
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    checkOutput("reqAbort req", memReqA, 1);
    abort = 1'b1;
    #1;
    checkOutput("reqAbort dropNow", memReqA, 0);
    waitCycles(1);
    abort = 1'b0;
    checkOutput("reqAbort idle", busyA, 0);
    checkOutput("reqAbort reqLow", memReqA, 0);

    // Reset in the middle of a long run.
    rootI = spinRoot;
    applyStimulus(1'b1, 1'b0);
    waitCycles(17);
    checkOutput("midRun steps17", stepsA, 17);
    checkOutput("midRun busy", busyA, 1);
    rst = 1'b1;
    waitCycles(1);
    checkReset("midReset");
    checkOutput("midReset errB", errB, 0);
    rst = 1'b0;
    waitCycles(1);
    rootI = leafRoot;
    applyStimulus(1'b1, 1'b0);
    checkOutput("postReset busy", busyA, 1);
    waitCycles(2);
    checkOutput("postReset done", doneA, 1);
    waitCycles(1);

    // start+abort together in IDLE, then start while busy.
    applyStimulus(1'b1, 1'b1);
    checkOutput("startAbort busy", busyA, 0);
    waitCycles(1);
    checkOutput("startAbort stillIdle", busyA, 0);
    checkOutput("startAbort steps", stepsA, 1);
    rootI = spinRoot;
    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    checkOutput("busyStart steps2", stepsA, 2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("busyStart steps3", stepsA, 3);
    checkOutput("busyStart busy", busyA, 1);
    waitCycles(1);
    checkOutput("busyStart steps4", stepsA, 4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("final idle", busyA, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
